fwrisc_regfile_arb: RTL and testbench

Arbiter/sequencer that shares the fwrisc register file between the core pipeline and a debug master (UART debug bridge). Core traffic passes through with zero added latency. Debug reads steal the rb read port under a two-cycle core stall. Debug writes use idle write-port cycles, or force a slot after a bounded wait.

---
 rtl/fwrisc_regfile_arb.sv | 122 ++++++++++++
 tb/tb_fwrisc_regfile_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fwrisc_regfile_arb.sv
// Shares the fwrisc register file between the core pipeline and a debug master.
// Core traffic passes straight through; debug reads steal rb, debug writes use idle write slots.
module fwrisc_regfile_arb #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  core_ra_raddr,
  input  logic [5:0]  core_rb_raddr,
  output logic [31:0] core_ra_rdata,
  output logic [31:0] core_rb_rdata,
  input  logic [5:0]  core_rd_waddr,
  input  logic [31:0] core_rd_wdata,
  input  logic        core_rd_wen,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [5:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic [5:0]  ra_raddr,
  output logic [5:0]  rb_raddr,
  output logic [5:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  input  logic [31:0] ra_rdata,
  input  logic [31:0] rb_rdata
);

  localparam int unsigned WCW = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_A,
    S_RD_D,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic [31:0]     rdata_q, rdata_d;

  assign ra_raddr      = core_ra_raddr;
  assign core_ra_rdata = ra_rdata;
  assign core_rb_rdata = rb_rdata;
  assign dbg_rdata     = rdata_q;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and port steering; write port and rb default to the core
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    rdata_d    = rdata_q;
    core_stall = 1'b0;
    dbg_ack    = 1'b0;
    rb_raddr   = core_rb_raddr;
    rd_waddr   = core_rd_waddr;
    rd_wdata   = core_rd_wdata;
    rd_wen     = core_rd_wen;

    case (state_q)
      S_IDLE: begin
        if (dbg_req) begin
          if (dbg_we) begin
            state_d = S_WR;
            wait_d  = '0;
          end else begin
            state_d = S_RD_A;
          end
        end
      end

      S_WR: begin
        // A forced slot suppresses the core write; the stalled core re-presents it
        if (!core_rd_wen || (wait_q == WAIT_LIMIT)) begin
          rd_waddr   = dbg_addr;
          rd_wdata   = dbg_wdata;
          rd_wen     = (dbg_addr != 6'd0);
          core_stall = core_rd_wen;
          state_d    = S_DONE;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end

      S_RD_A: begin
        core_stall = 1'b1;
        rb_raddr   = dbg_addr;
        state_d    = S_RD_D;
      end

      S_RD_D: begin
        core_stall = 1'b1;
        rdata_d    = rb_rdata;
        state_d    = S_DONE;
      end

      S_DONE: begin
        dbg_ack = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fwrisc_regfile_arb.sv
// Directed bench for fwrisc_regfile_arb with a small registered-address regfile model.
module tb_fwrisc_regfile_arb;

  logic        clock;
  logic        reset;
  logic [5:0]  core_ra_raddr, core_rb_raddr, core_rd_waddr;
  logic [31:0] core_ra_rdata, core_rb_rdata, core_rd_wdata;
  logic        core_rd_wen, core_stall;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic [5:0]  ra_raddr, rb_raddr, rd_waddr;
  logic [31:0] rd_wdata, ra_rdata, rb_rdata;
  logic        rd_wen;

  int n_cmp = 0;
  int n_err = 0;

  fwrisc_regfile_arb #(.MAX_WAIT(8)) dut (
    .clock(clock), .reset(reset),
    .core_ra_raddr(core_ra_raddr), .core_rb_raddr(core_rb_raddr),
    .core_ra_rdata(core_ra_rdata), .core_rb_rdata(core_rb_rdata),
    .core_rd_waddr(core_rd_waddr), .core_rd_wdata(core_rd_wdata),
    .core_rd_wen(core_rd_wen), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ra_raddr(ra_raddr), .rb_raddr(rb_raddr),
    .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen),
    .ra_rdata(ra_rdata), .rb_rdata(rb_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Regfile: registered read address, x0 reads zero
  logic [31:0] mem [64];
  logic [5:0]  ra_q, rb_q;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    ra_q = 6'd0;
    rb_q = 6'd0;
  end
  always @(posedge clock) begin
    if (rd_wen && rd_waddr != 6'd0) mem[rd_waddr] <= rd_wdata;
    ra_q <= ra_raddr;
    rb_q <= rb_raddr;
  end
  assign ra_rdata = (ra_q == 6'd0) ? 32'h0 : mem[ra_q];
  assign rb_rdata = (rb_q == 6'd0) ? 32'h0 : mem[rb_q];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Caller is in an IDLE cycle; that cycle is cycle 0
  task automatic dbg_write(input logic [5:0] a, input logic [31:0] d,
                           input int waits, input logic busy);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    #1;
    check("wr_c0_stall", 32'(core_stall), 32'(0));
    check("wr_c0_ack", 32'(dbg_ack), 32'(0));
    for (int k = 1; k <= waits; k++) begin
      tick(); #1;
      check("wr_wait_stall", 32'(core_stall), 32'(0));
      check("wr_wait_wen", 32'(rd_wen), 32'(1));
      check("wr_wait_waddr", 32'(rd_waddr), 32'(core_rd_waddr));
    end
    tick(); #1;
    check("wr_issue_wen", 32'(rd_wen), (a != 6'd0) ? 32'(1) : 32'(0));
    check("wr_issue_waddr", 32'(rd_waddr), 32'(a));
    check("wr_issue_wdata", rd_wdata, d);
    check("wr_issue_stall", 32'(core_stall), 32'(busy));
    check("wr_issue_ack", 32'(dbg_ack), 32'(0));
    tick();
    dbg_req = 1'b0;
    #1;
    check("wr_done_ack", 32'(dbg_ack), 32'(1));
    check("wr_done_stall", 32'(core_stall), 32'(0));
    check("wr_done_core_wen", 32'(rd_wen), 32'(busy));
    tick(); #1;
    check("wr_idle_ack", 32'(dbg_ack), 32'(0));
  endtask

  task automatic dbg_read(input logic [5:0] a, input logic [31:0] exp, input logic [31:0] rb_exp);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = a;
    #1;
    check("rd_c0_stall", 32'(core_stall), 32'(0));
    tick(); #1;
    check("rd_c1_stall", 32'(core_stall), 32'(1));
    check("rd_c1_rbaddr", 32'(rb_raddr), 32'(a));
    check("rd_c1_raaddr", 32'(ra_raddr), 32'(core_ra_raddr));
    tick(); #1;
    check("rd_c2_stall", 32'(core_stall), 32'(1));
    check("rd_c2_rbaddr", 32'(rb_raddr), 32'(core_rb_raddr));
    check("rd_c2_ack", 32'(dbg_ack), 32'(0));
    tick();
    dbg_req = 1'b0;
    #1;
    check("rd_c3_ack", 32'(dbg_ack), 32'(1));
    check("rd_c3_rdata", dbg_rdata, exp);
    check("rd_c3_stall", 32'(core_stall), 32'(0));
    check("rd_c3_core_rb", core_rb_rdata, rb_exp);
    tick(); #1;
    check("rd_idle_ack", 32'(dbg_ack), 32'(0));
    check("rd_hold_rdata", dbg_rdata, exp);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    core_ra_raddr = 6'd1; core_rb_raddr = 6'd3;
    core_rd_waddr = 6'd20; core_rd_wdata = 32'hC0C0_0000; core_rd_wen = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd3; dbg_wdata = 32'h33;

    repeat (3) begin
      tick(); #1;
      check("rst_ack", 32'(dbg_ack), 32'(0));
      check("rst_stall", 32'(core_stall), 32'(0));
      check("rst_rdata", dbg_rdata, 32'h0);
    end
    reset = 1'b1;
    dbg_write(6'd3, 32'h33, 0, 1'b0);

    // No request: regfile ports follow the core
    core_rd_wen = 1'b1;
    #1;
    check("idle_wen", 32'(rd_wen), 32'(1));
    check("idle_waddr", 32'(rd_waddr), 32'(20));
    check("idle_rbaddr", 32'(rb_raddr), 32'(3));
    check("idle_stall", 32'(core_stall), 32'(0));
    core_rd_wen = 1'b0;

    dbg_write(6'd5, 32'hDEAD_BEEF, 0, 1'b0);
    dbg_read(6'd5, 32'hDEAD_BEEF, 32'h33);
    dbg_write(6'd9, 32'h99, 0, 1'b0);
    dbg_read(6'd9, 32'h99, 32'h33);

    core_rd_wen = 1'b1;
    dbg_write(6'd7, 32'h1234_5678, 8, 1'b1);
    core_rd_wen = 1'b0;
    dbg_read(6'd7, 32'h1234_5678, 32'h33);
    dbg_read(6'd20, 32'hC0C0_0000, 32'h33);

    dbg_write(6'd0, 32'hFFFF_FFFF, 0, 1'b0);
    dbg_read(6'd0, 32'h0, 32'h33);

    // Reset asserted during the RD_D cycle aborts the read
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd9;
    tick(); tick(); #1;
    check("abort_rdd_stall", 32'(core_stall), 32'(1));
    #1 reset = 1'b0;
    #1;
    check("abort_stall", 32'(core_stall), 32'(0));
    check("abort_ack", 32'(dbg_ack), 32'(0));
    check("abort_rdata", dbg_rdata, 32'h0);
    tick(); #1;
    check("abort_ack_later", 32'(dbg_ack), 32'(0));
    tick();
    reset = 1'b1;
    dbg_read(6'd9, 32'h99, 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
